// File: rtl/instruction_fetch_if.sv
// Instruction ROM read port between the fetch stage (master) and the ROM (slave).
// Addresses are launched combinationally and data comes back one clock later.
interface instruction_fetch_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 24
);
    logic [PC_W-1:0]    imem_addr;
    logic               imem_en;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// ProtoCore fetch stage: owns the PC, drives a 1-cycle-latency instruction ROM and
// registers each fetched word into the IR, squashing the wrong-path word on a redirect.
module instruction_fetch #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 24,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               pc_overwrite,
    input  logic [PC_W-1:0]    target_addr,
    input  logic               halt_req,
    instruction_fetch_if.master imem,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_PRIME,
        S_RUN,
        S_HALT
    } state_t;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    fetch_pc, fetch_pc_nxt;
    logic               fetch_valid, fetch_valid_nxt;
    logic [INSTR_W-1:0] instruction_nxt;
    logic               instr_valid_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic               halted_nxt;

    // fetch_pc is the address whose word is on imem_data in the current cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_PRIME;
            fetch_pc    <= RESET_PC;
            fetch_valid <= 1'b0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            halted      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            fetch_valid <= fetch_valid_nxt;
            instruction <= instruction_nxt;
            instr_valid <= instr_valid_nxt;
            pc          <= pc_nxt;
            halted      <= halted_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        fetch_valid_nxt = fetch_valid;
        instruction_nxt = instruction;
        instr_valid_nxt = instr_valid;
        pc_nxt          = pc;
        halted_nxt      = halted;
        imem.imem_addr  = fetch_pc;
        imem.imem_en    = 1'b0;

        unique case (state)
            S_PRIME: begin
                imem.imem_addr  = RESET_PC;
                imem.imem_en    = 1'b1;
                fetch_pc_nxt    = RESET_PC;
                fetch_valid_nxt = 1'b1;
                state_nxt       = S_RUN;
            end

            S_RUN: begin
                imem.imem_en = 1'b1;
                if (stall) begin
                    // Re-read the same address so imem_data is still valid on release.
                    imem.imem_addr = fetch_pc;
                end else if (halt_req && instr_valid) begin
                    imem.imem_en    = 1'b0;
                    state_nxt       = S_HALT;
                    halted_nxt      = 1'b1;
                    instruction_nxt = '0;
                    instr_valid_nxt = 1'b0;
                end else if (pc_overwrite && instr_valid) begin
                    // The word arriving now is wrong-path: drop it and fetch the target.
                    imem.imem_addr  = target_addr;
                    instruction_nxt = '0;
                    instr_valid_nxt = 1'b0;
                    fetch_pc_nxt    = target_addr;
                    fetch_valid_nxt = 1'b1;
                end else begin
                    imem.imem_addr  = fetch_pc + 1'b1;
                    instruction_nxt = imem.imem_data;
                    pc_nxt          = fetch_pc;
                    instr_valid_nxt = fetch_valid;
                    fetch_pc_nxt    = fetch_pc + 1'b1;
                end
            end

            S_HALT: begin
                instruction_nxt = '0;
                instr_valid_nxt = 1'b0;
                halted_nxt      = 1'b1;
            end

            default: begin
                state_nxt = S_PRIME;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: drives a behavioural 1-cycle ROM and checks
// the IR/PC stream through redirects, stalls, wrap, halt and asynchronous reset.
module tb_instruction_fetch;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 24;

    logic               clk;
    logic               rst;
    logic               stall;
    logic               pc_overwrite;
    logic [PC_W-1:0]    target_addr;
    logic               halt_req;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               halted;
    logic [INSTR_W-1:0] rom_q;

    int checks = 0;
    int errors = 0;

    instruction_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instruction_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .pc_overwrite (pc_overwrite),
        .target_addr  (target_addr),
        .halt_req     (halt_req),
        .imem         (bus.master),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .halted       (halted)
    );

    // Each ROM word encodes its own address so a wrong word is visible.
    function automatic logic [INSTR_W-1:0] rom_word(input logic [PC_W-1:0] a);
        return {8'h5A, a, ~a};
    endfunction

    always @(posedge clk) if (bus.imem_en) rom_q <= rom_word(bus.imem_addr);
    assign bus.imem_data = rom_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ir(input string tag, input logic [PC_W-1:0] exp_pc);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"},    32'(pc), 32'(exp_pc));
        check({tag, "_instr"}, 32'(instruction), 32'(rom_word(exp_pc)));
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, 32'(instruction), 32'd0);
    endtask

    task automatic redirect(input logic [PC_W-1:0] tgt);
        pc_overwrite = 1'b1;
        target_addr  = tgt;
        #1;
        check("redir_addr", 32'(bus.imem_addr), 32'(tgt));
        step();
        pc_overwrite = 1'b0;
        check_bubble("redir_bubble");
    endtask

    initial begin
        rst          = 1'b0;
        stall        = 1'b0;
        pc_overwrite = 1'b0;
        target_addr  = '0;
        halt_req     = 1'b0;
        rom_q        = '0;

        // Reset state
        #3;
        check("rst_instr",  32'(instruction), 32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_pc",     32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("prime_en",   32'(bus.imem_en), 32'd1);
        check("prime_addr", 32'(bus.imem_addr), 32'd0);

        // 1. First valid word after the second edge, then one per cycle.
        step();
        rst = 1'b1;
        step();
        check_bubble("edge1");
        step();
        check_ir("edge2", 8'h00);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_ir("seq", 8'(i));
        end

        // 2. Redirect at pc=05 to 40: one bubble, then 40, 41.
        redirect(8'h40);
        step();
        check_ir("tgt40", 8'h40);
        step();
        check_ir("tgt41", 8'h41);

        // 3. Stall three cycles at pc=03.
        redirect(8'h03);
        step();
        check_ir("pre_stall", 8'h03);
        stall = 1'b1;
        #1;
        check("stall_addr", 32'(bus.imem_addr), 32'h04);
        for (int i = 0; i < 3; i++) begin
            step();
            check_ir("stall_hold", 8'h03);
        end
        stall = 1'b0;
        step();
        check_ir("post_stall4", 8'h04);
        step();
        check_ir("post_stall5", 8'h05);

        // 5. Wrap; an overwrite during the bubble must be ignored.
        redirect(8'hFE);
        pc_overwrite = 1'b1;
        target_addr  = 8'h80;
        step();
        pc_overwrite = 1'b0;
        check_ir("wrap_fe", 8'hFE);
        step();
        check_ir("wrap_ff", 8'hFF);
        step();
        check_ir("wrap_00", 8'h00);
        step();
        check_ir("wrap_01", 8'h01);

        // 4. Halt beats a simultaneous redirect at pc=07 and is sticky.
        redirect(8'h07);
        step();
        check_ir("pre_halt", 8'h07);
        halt_req     = 1'b1;
        pc_overwrite = 1'b1;
        target_addr  = 8'h20;
        #1;
        check("halt_req_en", 32'(bus.imem_en), 32'd0);
        step();
        check("halt_halted", 32'(halted), 32'd1);
        check_bubble("halt");
        check("halt_en", 32'(bus.imem_en), 32'd0);
        for (int i = 0; i < 20; i++) begin
            stall        = 1'($urandom_range(0, 1));
            pc_overwrite = 1'($urandom_range(0, 1));
            halt_req     = 1'($urandom_range(0, 1));
            target_addr  = 8'($urandom_range(0, 255));
            step();
            check("halt_sticky", 32'(halted), 32'd1);
            check("halt_valid",  32'(instr_valid), 32'd0);
            check("halt_instr",  32'(instruction), 32'd0);
            check("halt_en_hold", 32'(bus.imem_en), 32'd0);
        end

        // 6a. Reset while halted clears without a clock edge.
        rst = 1'b0;
        #1;
        check("arst_halted", 32'(halted), 32'd0);
        check("arst_valid",  32'(instr_valid), 32'd0);
        check("arst_pc",     32'(pc), 32'd0);
        stall        = 1'b0;
        pc_overwrite = 1'b0;
        halt_req     = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_bubble("restart_edge1");
        step();
        check_ir("restart_edge2", 8'h00);
        step();
        step();
        check_ir("restart_seq2", 8'h02);

        // 6b. Reset during a stall clears immediately, then restarts via PRIME.
        stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst2_valid", 32'(instr_valid), 32'd0);
        check("arst2_pc",    32'(pc), 32'd0);
        check("arst2_instr", 32'(instruction), 32'd0);
        stall = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_bubble("restart2_edge1");
        step();
        check_ir("restart2_edge2", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
